// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the single cartridge SDRAM port among three requesters: the flash
// loader (LD), the PPU CHR fetch (PPU) and the CPU PRG fetch (CPU). One request
// is latched at a time and held stable on the sd_* command outputs for the
// controller's sync-aligned two-slot access. At the second sync after the
// grant, read data is captured for the winner and a one-cycle ack is pulsed.
// A starvation guard lets the CPU win after it has lost STARVE_LIMIT
// consecutive grants to the PPU.
//
// Ports
//   clock, reset           system clock; synchronous active-high reset
//   sync                   one-cycle slot strobe from the SDRAM timing
//   sd_ready               controller init complete; no grants while low
//   ld_req/addr/wdata      loader (always a full-word write), ld_ack pulse
//   ppu_req/we/addr/ds/wdata, ppu_ack, ppu_rdata    PPU port
//   cpu_req/we/addr/ds/wdata, cpu_ack, cpu_rdata    CPU port
//   sd_we, sd_oe, sd_addr, sd_ds, sd_din, sd_dout   controller command/data
//   busy                   high whenever an access is in flight
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sync,
  input  logic              sd_ready,

  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_wdata,
  output logic              ld_ack,

  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [1:0]        ppu_ds,
  input  logic [15:0]       ppu_wdata,
  output logic              ppu_ack,
  output logic [15:0]       ppu_rdata,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_ds,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,

  output logic              sd_we,
  output logic              sd_oe,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [1:0]        sd_ds,
  output logic [15:0]       sd_din,
  input  logic [15:0]       sd_dout,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request
    ARMED = 2'd1,  // command presented, waiting for controller to capture it
    SLOT1 = 2'd2   // controller working, data returns on the next sync
  } state_t;

  typedef enum logic [1:0] {
    SRC_LD  = 2'd0,
    SRC_PPU = 2'd1,
    SRC_CPU = 2'd2
  } src_t;

  // Counter only needs to reach STARVE_LIMIT; it saturates there.
  localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_t              state_q, state_d;
  src_t                owner_q, owner_d;
  src_t                win;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic              sd_we_d, sd_oe_d;
  logic [ADDR_W-1:0] sd_addr_d;
  logic [1:0]        sd_ds_d;
  logic [15:0]       sd_din_d;
  logic              ld_ack_d, ppu_ack_d, cpu_ack_d;
  logic [15:0]       ppu_rdata_d, cpu_rdata_d;

  logic any_req;
  logic any_ack;
  logic grant;

  assign any_req = ld_req | ppu_req | cpu_req;
  // The ack cycle is spent in IDLE with the just-served requester still
  // holding req; granting then would serve it twice, so grants wait a cycle.
  assign any_ack = ld_ack | ppu_ack | cpu_ack;
  assign grant   = (state_q == IDLE) && sd_ready && !any_ack && any_req;
  assign busy    = (state_q != IDLE);

  // Winner selection. Loader always first; CPU jumps the PPU once starved.
  always_comb begin
    win = SRC_CPU;
    if (ld_req)
      win = SRC_LD;
    else if (cpu_req && (starve_q >= STARVE_MAX))
      win = SRC_CPU;
    else if (ppu_req)
      win = SRC_PPU;
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    sd_we_d     = sd_we;
    sd_oe_d     = sd_oe;
    sd_addr_d   = sd_addr;
    sd_ds_d     = sd_ds;
    sd_din_d    = sd_din;
    ld_ack_d    = 1'b0;
    ppu_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    ppu_rdata_d = ppu_rdata;
    cpu_rdata_d = cpu_rdata;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = win;
          state_d = ARMED;
          case (win)
            SRC_LD: begin
              sd_we_d   = 1'b1;
              sd_oe_d   = 1'b0;
              sd_addr_d = ld_addr;
              sd_ds_d   = 2'b11;
              sd_din_d  = ld_wdata;
            end
            SRC_PPU: begin
              sd_we_d   = ppu_we;
              sd_oe_d   = !ppu_we;
              sd_addr_d = ppu_addr;
              sd_ds_d   = ppu_ds;
              sd_din_d  = ppu_wdata;
            end
            default: begin
              sd_we_d   = cpu_we;
              sd_oe_d   = !cpu_we;
              sd_addr_d = cpu_addr;
              sd_ds_d   = cpu_ds;
              sd_din_d  = cpu_wdata;
            end
          endcase

          // Starvation bookkeeping: only a PPU win over a waiting CPU counts;
          // a loader win over a waiting CPU leaves the count alone.
          if (!cpu_req || win == SRC_CPU)
            starve_d = '0;
          else if (win == SRC_PPU && starve_q < STARVE_MAX)
            starve_d = starve_q + 1'b1;
        end
      end

      ARMED: begin
        if (sync)
          state_d = SLOT1;
      end

      SLOT1: begin
        if (sync) begin
          state_d = IDLE;
          sd_we_d = 1'b0;
          sd_oe_d = 1'b0;
          case (owner_q)
            SRC_LD:  ld_ack_d = 1'b1;
            SRC_PPU: begin
              ppu_ack_d = 1'b1;
              if (!sd_we) ppu_rdata_d = sd_dout;
            end
            default: begin
              cpu_ack_d = 1'b1;
              if (!sd_we) cpu_rdata_d = sd_dout;
            end
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; an access cut short by
  // reset never acks, and the still-held request is simply served again.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= SRC_LD;
      starve_q  <= '0;
      sd_we     <= 1'b0;
      sd_oe     <= 1'b0;
      sd_addr   <= '0;
      sd_ds     <= 2'b00;
      sd_din    <= 16'h0000;
      ld_ack    <= 1'b0;
      ppu_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      ppu_rdata <= 16'h0000;
      cpu_rdata <= 16'h0000;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      sd_we     <= sd_we_d;
      sd_oe     <= sd_oe_d;
      sd_addr   <= sd_addr_d;
      sd_ds     <= sd_ds_d;
      sd_din    <= sd_din_d;
      ld_ack    <= ld_ack_d;
      ppu_ack   <= ppu_ack_d;
      cpu_ack   <= cpu_ack_d;
      ppu_rdata <= ppu_rdata_d;
      cpu_rdata <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Directed bench for sdram_port_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge. sync is either driven by hand (exact slot timing)
// or generated every fourth cycle while sync_auto is set.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 20;

  logic              clock;
  logic              reset;
  logic              sync;
  logic              sd_ready;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_wdata;
  logic              ld_ack;
  logic              ppu_req;
  logic              ppu_we;
  logic [ADDR_W-1:0] ppu_addr;
  logic [1:0]        ppu_ds;
  logic [15:0]       ppu_wdata;
  logic              ppu_ack;
  logic [15:0]       ppu_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [1:0]        cpu_ds;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;
  logic              sd_we;
  logic              sd_oe;
  logic [ADDR_W-1:0] sd_addr;
  logic [1:0]        sd_ds;
  logic [15:0]       sd_din;
  logic [15:0]       sd_dout;
  logic              busy;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .sync      (sync),
    .sd_ready  (sd_ready),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ppu_req   (ppu_req),
    .ppu_we    (ppu_we),
    .ppu_addr  (ppu_addr),
    .ppu_ds    (ppu_ds),
    .ppu_wdata (ppu_wdata),
    .ppu_ack   (ppu_ack),
    .ppu_rdata (ppu_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_ds    (cpu_ds),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .sd_we     (sd_we),
    .sd_oe     (sd_oe),
    .sd_addr   (sd_addr),
    .sd_ds     (sd_ds),
    .sd_din    (sd_din),
    .sd_dout   (sd_dout),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit sync_auto = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; outputs now reflect the rising edge
  // just passed, and anything set here applies to the next rising edge.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (sync_auto) sync = (cyc % 4 == 0);
  endtask

  // Returns 0=LD, 1=PPU, 2=CPU, or -1 if no ack appeared within budget.
  task automatic wait_ack(output int src, input int budget);
    bit done;
    src  = -1;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (ld_ack)       begin src = 0; done = 1'b1; end
      else if (ppu_ack) begin src = 1; done = 1'b1; end
      else if (cpu_ack) begin src = 2; done = 1'b1; end
    end
  endtask

  task automatic wait_busy(output bit seen, input int budget);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (busy) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int src;
    bit seen;
    bit any_busy;
    int extra;
    int order[3];
    int exp_seq[6] = '{1, 1, 2, 1, 1, 2};

    reset = 1'b1; sync = 1'b0; sd_ready = 1'b0; sd_dout = 16'h0000;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_ds = 2'b11; ppu_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_ds = 2'b11; cpu_wdata = '0;

    // ---- Reset values ----
    repeat (3) step();
    check("rst_busy",      busy,      1'b0);
    check("rst_sd_we",     sd_we,     1'b0);
    check("rst_sd_oe",     sd_oe,     1'b0);
    check("rst_sd_addr",   sd_addr,   20'h0);
    check("rst_sd_ds",     sd_ds,     2'b00);
    check("rst_sd_din",    sd_din,    16'h0);
    check("rst_ld_ack",    ld_ack,    1'b0);
    check("rst_ppu_ack",   ppu_ack,   1'b0);
    check("rst_cpu_ack",   cpu_ack,   1'b0);
    check("rst_ppu_rdata", ppu_rdata, 16'h0);
    check("rst_cpu_rdata", cpu_rdata, 16'h0);
    reset = 1'b0; sd_ready = 1'b1;
    step();

    // ---- 1: PPU read, hand-timed syncs; sync in the grant cycle is ignored ----
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 20'h00123; ppu_ds = 2'b11;
    sync = 1'b1; sd_dout = 16'hDEAD;
    step();
    check("t1_grant_busy", busy,    1'b1);
    check("t1_grant_oe",   sd_oe,   1'b1);
    check("t1_grant_we",   sd_we,   1'b0);
    check("t1_grant_addr", sd_addr, 20'h00123);
    check("t1_grant_ds",   sd_ds,   2'b11);
    sync = 1'b0;
    step();
    check("t1_armed_ack",  ppu_ack, 1'b0);
    check("t1_armed_oe",   sd_oe,   1'b1);
    sync = 1'b1;
    step();
    check("t1_slot1_ack",  ppu_ack, 1'b0);
    check("t1_slot1_oe",   sd_oe,   1'b1);
    check("t1_slot1_busy", busy,    1'b1);
    sync = 1'b0; sd_dout = 16'hBEEF;
    step();
    check("t1_wait_ack",   ppu_ack, 1'b0);
    sync = 1'b1;
    step();
    check("t1_ack",        ppu_ack,   1'b1);
    check("t1_rdata",      ppu_rdata, 16'hBEEF);
    check("t1_done_oe",    sd_oe,     1'b0);
    check("t1_done_busy",  busy,      1'b0);
    check("t1_cpu_ack",    cpu_ack,   1'b0);
    sync = 1'b0; ppu_req = 1'b0; sd_dout = 16'h0000;
    step();
    check("t1_ack_1cyc",   ppu_ack,   1'b0);
    check("t1_rdata_hold", ppu_rdata, 16'hBEEF);
    check("t1_idle",       busy,      1'b0);

    // ---- 2: simultaneous LD/PPU/CPU -> LD, PPU, CPU ----
    sync_auto = 1'b1; sd_dout = 16'h5A5A;
    ld_req = 1'b1;  ld_addr = 20'h0ABCD; ld_wdata = 16'h1357;
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 20'h00200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h08100;
    wait_busy(seen, 10);
    check("t2_ld_grant_seen", seen,    1'b1);
    check("t2_ld_we",         sd_we,   1'b1);
    check("t2_ld_ds",         sd_ds,   2'b11);
    check("t2_ld_din",        sd_din,  16'h1357);
    check("t2_ld_addr",       sd_addr, 20'h0ABCD);
    for (int k = 0; k < 3; k++) begin
      wait_ack(src, 40);
      order[k] = src;
      if (src == 0) ld_req  = 1'b0;
      if (src == 1) ppu_req = 1'b0;
      if (src == 2) cpu_req = 1'b0;
    end
    check("t2_order0", order[0], 32'd0);
    check("t2_order1", order[1], 32'd1);
    check("t2_order2", order[2], 32'd2);
    extra = 0;
    repeat (20) begin
      step();
      if (ld_ack || ppu_ack || cpu_ack) extra++;
    end
    check("t2_no_extra_acks", extra, 32'd0);

    // ---- 3: starvation guard with PPU and CPU both held ----
    ppu_req = 1'b1; cpu_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(src, 40);
      check($sformatf("t3_grant%0d", k), src, exp_seq[k]);
    end
    ppu_req = 1'b0; cpu_req = 1'b0;
    step();
    check("t3_cpu_rdata", cpu_rdata, 16'h5A5A);

    // ---- 4: CPU byte write ----
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ds = 2'b01; cpu_wdata = 16'h00A5;
    cpu_addr = 20'h08000; sd_dout = 16'h1234;
    wait_busy(seen, 10);
    check("t4_grant_seen", seen,    1'b1);
    check("t4_we",         sd_we,   1'b1);
    check("t4_oe",         sd_oe,   1'b0);
    check("t4_ds",         sd_ds,   2'b01);
    check("t4_din",        sd_din,  16'h00A5);
    check("t4_addr",       sd_addr, 20'h08000);
    wait_ack(src, 40);
    check("t4_ack_src",    src,       32'd2);
    check("t4_rdata_kept", cpu_rdata, 16'h5A5A);
    check("t4_we_dropped", sd_we,     1'b0);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_ds = 2'b11;
    step();

    // ---- 5: reset during SLOT1 ----
    sync_auto = 1'b0; sync = 1'b0;
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 20'h00777; ppu_ds = 2'b11;
    step();
    check("t5_grant_busy", busy, 1'b1);
    sync = 1'b1;
    step();
    check("t5_slot1_busy", busy, 1'b1);
    sync = 1'b0; reset = 1'b1;
    step();
    check("t5_rst_busy",   busy,      1'b0);
    check("t5_rst_oe",     sd_oe,     1'b0);
    check("t5_rst_addr",   sd_addr,   20'h0);
    check("t5_rst_ds",     sd_ds,     2'b00);
    check("t5_rst_prdata", ppu_rdata, 16'h0);
    check("t5_rst_crdata", cpu_rdata, 16'h0);
    sync = 1'b1;
    step();
    check("t5_rst_no_ack", ppu_ack, 1'b0);
    reset = 1'b0; sync = 1'b0;
    step();
    check("t5_regrant_busy", busy,    1'b1);
    check("t5_regrant_addr", sd_addr, 20'h00777);
    check("t5_regrant_oe",   sd_oe,   1'b1);
    sync = 1'b1; step();
    sync = 1'b0; step();
    check("t5_no_early_ack", ppu_ack, 1'b0);
    sync = 1'b1; sd_dout = 16'h0F0F;
    step();
    check("t5_ack",   ppu_ack,   1'b1);
    check("t5_rdata", ppu_rdata, 16'h0F0F);
    ppu_req = 1'b0; sync = 1'b0;
    step();

    // ---- 6: sd_ready low blocks grants; grant when it rises ----
    sync_auto = 1'b1; sd_ready = 1'b0;
    ppu_req = 1'b1; ppu_addr = 20'h00456;
    any_busy = 1'b0;
    repeat (40) begin
      step();
      if (busy) any_busy = 1'b1;
    end
    check("t6_no_grant", any_busy, 1'b0);
    sd_ready = 1'b1;
    step();
    check("t6_grant_busy", busy,    1'b1);
    check("t6_grant_addr", sd_addr, 20'h00456);
    wait_ack(src, 40);
    check("t6_ack_src", src, 32'd1);
    ppu_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
